// File: rtl/mod_mul.sv
// rtl/mod_mul.sv - shift-add multiply-accumulate num = res*den + rem, one multiplier bit per clock; optional MOD_MUL_CHECK_EN adds err
module mod_mul #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   res_in,
    input  logic [W-1:0]   den_in,
    input  logic [W-1:0]   rem_in,
    output logic [2*W-1:0] num_out,
    output logic           ovf,
`ifdef MOD_MUL_CHECK_EN
    output logic           err,
`endif
    output logic           busy,
    output logic           done
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   res_q, res_d;
    logic [2*W-1:0] den_sh_q, den_sh_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] num_out_q, num_out_d;
    logic           ovf_q, ovf_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [2*W-1:0] acc_next;
`ifdef MOD_MUL_CHECK_EN
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   den_q, den_d;
    logic           err_q, err_d;
`endif

    // Accumulator after this iteration: add the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        acc_next = acc_q;
        if (res_q[0]) begin
            acc_next = acc_q + den_sh_q;
        end
    end

    // Next-state logic: start always wins (load/abort), otherwise iterate while in RUN
    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        den_sh_d  = den_sh_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        num_out_d = num_out_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        done_d    = done_q;
`ifdef MOD_MUL_CHECK_EN
        rem_d     = rem_q;
        den_d     = den_q;
        err_d     = err_q;
`endif
        if (start) begin
            res_d    = res_in;
            den_sh_d = {{W{1'b0}}, den_in};
            acc_d    = {{W{1'b0}}, rem_in};
            cnt_d    = '0;
            done_d   = 1'b0;
            busy_d   = 1'b1;
            state_d  = RUN;
`ifdef MOD_MUL_CHECK_EN
            rem_d    = rem_in;
            den_d    = den_in;
            err_d    = 1'b0;
`endif
        end else if (state_q == RUN) begin
            acc_d    = acc_next;
            den_sh_d = den_sh_q << 1;
            res_d    = res_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                num_out_d = acc_next;
                ovf_d     = |acc_next[2*W-1:W];
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = DONE;
`ifdef MOD_MUL_CHECK_EN
                // A remainder not below the divisor cannot come from a valid division (covers den=0)
                err_d     = (rem_q >= den_q);
`endif
            end
        end
    end

    // State and datapath registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            res_q     <= '0;
            den_sh_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            num_out_q <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MOD_MUL_CHECK_EN
            rem_q     <= '0;
            den_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            den_sh_q  <= den_sh_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            num_out_q <= num_out_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MOD_MUL_CHECK_EN
            rem_q     <= rem_d;
            den_q     <= den_d;
            err_q     <= err_d;
`endif
        end
    end

    assign num_out = num_out_q;
    assign ovf     = ovf_q;
    assign busy    = busy_q;
    assign done    = done_q;
`ifdef MOD_MUL_CHECK_EN
    assign err     = err_q;
`endif

endmodule
